// File: rtl/types_pkg.sv
// Shared types for the dispatch stage: rename packet, dispatch payload and FU channel indices.
package types_pkg;

  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_BR  = 1;
  localparam int unsigned FU_MEM = 2;

  localparam int unsigned PKT_PREG_W = 7;
  localparam int unsigned PKT_ROB_W  = 5;

  // Packet coming out of rename.
  typedef struct packed {
    logic [6:0]            opcode;
    logic [31:0]           pc;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [31:0]           imm;
    logic [PKT_PREG_W-1:0] ps1;
    logic [PKT_PREG_W-1:0] ps2;
    logic [PKT_PREG_W-1:0] pd_new;
    logic [PKT_PREG_W-1:0] pd_old;
  } rename_data;

  // Payload written into the selected reservation station.
  typedef struct packed {
    logic [6:0]            opcode;
    logic [31:0]           pc;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [31:0]           imm;
    logic [PKT_PREG_W-1:0] prd;
    logic [PKT_PREG_W-1:0] pr1;
    logic [PKT_PREG_W-1:0] pr2;
    logic [PKT_ROB_W-1:0]  rob_index;
    logic                  pr1_ready;
    logic                  pr2_ready;
  } dispatch_pipeline_data;

endpackage

// File: rtl/dispatch_nch_if.sv
// Signal bundle around dispatch_nch, used by the environment to hook the block up.
// master: rename/RS/PRF/ROB side driving the block; slave: the dispatch block itself.
interface dispatch_nch_if
  import types_pkg::*;
#(
  parameter int unsigned NUM_FU  = 3,
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned PREG_W  = 7,
  parameter int unsigned ROB_W   = 5
);
  logic                       valid_in;
  rename_data                 data_in;
  logic [NUM_FU-1:0]          fu_sel_in;
  logic                       ready_in;
  logic [NUM_FU-1:0]          rs_valid_out;
  dispatch_pipeline_data      rs_data_out;
  logic [NUM_FU-1:0]          rs_ready_in;
  logic [PREG_W-1:0]          nr_reg_out;
  logic                       nr_valid_out;
  logic [PREG_W-1:0]          query_ps1;
  logic [PREG_W-1:0]          query_ps2;
  logic                       pr1_is_ready;
  logic                       pr2_is_ready;
  logic [NUM_CDB*PREG_W-1:0]  cdb_preg_in;
  logic [NUM_CDB-1:0]         cdb_valid_in;
  logic                       rob_we_out;
  logic [PREG_W-1:0]          rob_pd_new_out;
  logic [PREG_W-1:0]          rob_pd_old_out;
  logic [31:0]                rob_pc_out;
  logic [ROB_W-1:0]           rob_tag_in;
  logic                       rob_full_in;
  logic                       mispredict;
  logic                       err_out;

  modport master (
    output valid_in, data_in, fu_sel_in, rs_ready_in, pr1_is_ready, pr2_is_ready,
           cdb_preg_in, cdb_valid_in, rob_tag_in, rob_full_in, mispredict,
    input  ready_in, rs_valid_out, rs_data_out, nr_reg_out, nr_valid_out,
           query_ps1, query_ps2, rob_we_out, rob_pd_new_out, rob_pd_old_out,
           rob_pc_out, err_out
  );

  modport slave (
    input  valid_in, data_in, fu_sel_in, rs_ready_in, pr1_is_ready, pr2_is_ready,
           cdb_preg_in, cdb_valid_in, rob_tag_in, rob_full_in, mispredict,
    output ready_in, rs_valid_out, rs_data_out, nr_reg_out, nr_valid_out,
           query_ps1, query_ps2, rob_we_out, rob_pd_new_out, rob_pd_old_out,
           rob_pc_out, err_out
  );

endinterface

// File: rtl/dispatch_hold_slot.sv
// One per-channel holding slot: valid bit, packet and operand-ready bits with CDB wakeup.
// Ports: capture loads pkt_in, release_slot frees the slot (capture wins), flush empties it;
// r1_ready_c/r2_ready_c fold a same-cycle CDB match into the stored ready bits.
module dispatch_hold_slot
  import types_pkg::*;
#(
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned PREG_W  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic                      release_slot,
  input  logic                      flush,
  input  rename_data                pkt_in,
  input  logic                      pr1_is_ready,
  input  logic                      pr2_is_ready,
  input  logic [NUM_CDB*PREG_W-1:0] cdb_preg_in,
  input  logic [NUM_CDB-1:0]        cdb_valid_in,
  output logic                      valid,
  output rename_data                pkt,
  output logic                      r1_ready_c,
  output logic                      r2_ready_c
);

  logic r1_q, r2_q;
  logic hit_in1, hit_in2, hit_q1, hit_q2;

  // CDB tag matches against the incoming packet and the held packet.
  always_comb begin
    hit_in1 = 1'b0;
    hit_in2 = 1'b0;
    hit_q1  = 1'b0;
    hit_q2  = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid_in[k]) begin
        if (cdb_preg_in[k*PREG_W +: PREG_W] == PREG_W'(pkt_in.ps1)) hit_in1 = 1'b1;
        if (cdb_preg_in[k*PREG_W +: PREG_W] == PREG_W'(pkt_in.ps2)) hit_in2 = 1'b1;
        if (cdb_preg_in[k*PREG_W +: PREG_W] == PREG_W'(pkt.ps1))    hit_q1  = 1'b1;
        if (cdb_preg_in[k*PREG_W +: PREG_W] == PREG_W'(pkt.ps2))    hit_q2  = 1'b1;
      end
    end
  end

  // Slot state; p0 is hardwired ready, ready bits only ever set while held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      pkt   <= '0;
      r1_q  <= 1'b0;
      r2_q  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      pkt   <= pkt_in;
      r1_q  <= (pkt_in.ps1 == '0) | pr1_is_ready | hit_in1;
      r2_q  <= (pkt_in.ps2 == '0) | pr2_is_ready | hit_in2;
    end else if (release_slot) begin
      valid <= 1'b0;
    end else if (valid) begin
      r1_q <= r1_q | hit_q1;
      r2_q <= r2_q | hit_q2;
    end
  end

  assign r1_ready_c = r1_q | hit_q1;
  assign r2_ready_c = r2_q | hit_q2;

endmodule

// File: rtl/dispatch_nch.sv
// N-channel dispatch: holds one packet per FU channel and issues at most one per cycle
// round-robin to its reservation station, allocating the ROB entry and marking pd_new busy.
// Ports: rename handshake (valid_in/data_in/fu_sel_in/ready_in), per-RS strobes and shared
// payload, PRF query and busy mark, CDB wakeup, ROB allocate, mispredict flush, sticky err_out.
module dispatch_nch
  import types_pkg::*;
#(
  parameter int unsigned NUM_FU  = 3,
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned PREG_W  = 7,
  parameter int unsigned ROB_W   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  rename_data                data_in,
  input  logic [NUM_FU-1:0]         fu_sel_in,
  output logic                      ready_in,
  output logic [NUM_FU-1:0]         rs_valid_out,
  output dispatch_pipeline_data     rs_data_out,
  input  logic [NUM_FU-1:0]         rs_ready_in,
  output logic [PREG_W-1:0]         nr_reg_out,
  output logic                      nr_valid_out,
  output logic [PREG_W-1:0]         query_ps1,
  output logic [PREG_W-1:0]         query_ps2,
  input  logic                      pr1_is_ready,
  input  logic                      pr2_is_ready,
  input  logic [NUM_CDB*PREG_W-1:0] cdb_preg_in,
  input  logic [NUM_CDB-1:0]        cdb_valid_in,
  output logic                      rob_we_out,
  output logic [PREG_W-1:0]         rob_pd_new_out,
  output logic [PREG_W-1:0]         rob_pd_old_out,
  output logic [31:0]               rob_pc_out,
  input  logic [ROB_W-1:0]          rob_tag_in,
  input  logic                      rob_full_in,
  input  logic                      mispredict,
  output logic                      err_out
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] slot_valid;
  logic [NUM_FU-1:0] slot_r1;
  logic [NUM_FU-1:0] slot_r2;
  rename_data        slot_pkt [NUM_FU];

  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant_vec;
  logic [NUM_FU-1:0] capture_vec;
  logic              grant_any;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  rr_ptr;
  logic              sel_ok;
  rename_data        win_pkt;

  assign sel_ok   = $onehot(fu_sel_in);
  assign eligible = slot_valid & rs_ready_in & {NUM_FU{~rob_full_in & ~mispredict}};

  // Round-robin pick: first eligible slot at or after rr_ptr.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_FU);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
    if (grant_any) grant_vec[winner] = 1'b1;
  end

  // A slot being granted this cycle may be refilled in the same cycle.
  assign ready_in    = ~mispredict & sel_ok & ((fu_sel_in & (~slot_valid | grant_vec)) != '0);
  assign capture_vec = fu_sel_in & {NUM_FU{valid_in & ready_in}};

  assign query_ps1 = PREG_W'(data_in.ps1);
  assign query_ps2 = PREG_W'(data_in.ps2);

  for (genvar c = 0; c < NUM_FU; c++) begin : g_slot
    dispatch_hold_slot #(
      .NUM_CDB (NUM_CDB),
      .PREG_W  (PREG_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .capture      (capture_vec[c]),
      .release_slot (grant_vec[c]),
      .flush        (mispredict),
      .pkt_in       (data_in),
      .pr1_is_ready (pr1_is_ready),
      .pr2_is_ready (pr2_is_ready),
      .cdb_preg_in  (cdb_preg_in),
      .cdb_valid_in (cdb_valid_in),
      .valid        (slot_valid[c]),
      .pkt          (slot_pkt[c]),
      .r1_ready_c   (slot_r1[c]),
      .r2_ready_c   (slot_r2[c])
    );
  end

  // Pointer advances past the winner; holds on idle and flush cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      if (int'(winner) == NUM_FU - 1) rr_ptr <= '0;
      else                            rr_ptr <= winner + PTR_W'(1);
    end
  end

  // Sticky flag for packets with a zero or multi-hot channel select.
  always_ff @(posedge clk) begin
    if (!reset)                  err_out <= 1'b0;
    else if (valid_in && !sel_ok) err_out <= 1'b1;
  end

  // Winner payload mux; everything reads zero when nothing is granted.
  always_comb begin
    win_pkt        = slot_pkt[winner];
    rs_valid_out   = grant_vec;
    rob_we_out     = grant_any;
    nr_valid_out   = grant_any;
    rs_data_out    = '0;
    nr_reg_out     = '0;
    rob_pd_new_out = '0;
    rob_pd_old_out = '0;
    rob_pc_out     = '0;
    if (grant_any) begin
      rs_data_out.opcode    = win_pkt.opcode;
      rs_data_out.pc        = win_pkt.pc;
      rs_data_out.func3     = win_pkt.func3;
      rs_data_out.func7     = win_pkt.func7;
      rs_data_out.imm       = win_pkt.imm;
      rs_data_out.prd       = win_pkt.pd_new;
      rs_data_out.pr1       = win_pkt.ps1;
      rs_data_out.pr2       = win_pkt.ps2;
      rs_data_out.rob_index = PKT_ROB_W'(rob_tag_in);
      rs_data_out.pr1_ready = slot_r1[winner];
      rs_data_out.pr2_ready = slot_r2[winner];
      nr_reg_out            = PREG_W'(win_pkt.pd_new);
      rob_pd_new_out        = PREG_W'(win_pkt.pd_new);
      rob_pd_old_out        = PREG_W'(win_pkt.pd_old);
      rob_pc_out            = win_pkt.pc;
    end
  end

endmodule

// File: tb/tb_dispatch_nch.sv
// Self-checking bench for dispatch_nch: directed scenarios, expected dispatches queued in
// issue order at stimulus time and compared by a negedge monitor whenever a grant appears.
module tb_dispatch_nch;
  import types_pkg::*;

  localparam int unsigned NFU  = 3;
  localparam int unsigned NCDB = 3;
  localparam int unsigned PW   = 7;
  localparam int unsigned RW   = 5;
  localparam logic [RW-1:0] ROB_TAG  = 5'd17;
  localparam logic [31:0]   IMM_MASK = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dispatch_nch_if #(.NUM_FU(NFU), .NUM_CDB(NCDB), .PREG_W(PW), .ROB_W(RW)) bus ();

  dispatch_nch #(.NUM_FU(NFU), .NUM_CDB(NCDB), .PREG_W(PW), .ROB_W(RW)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (bus.valid_in),
    .data_in        (bus.data_in),
    .fu_sel_in      (bus.fu_sel_in),
    .ready_in       (bus.ready_in),
    .rs_valid_out   (bus.rs_valid_out),
    .rs_data_out    (bus.rs_data_out),
    .rs_ready_in    (bus.rs_ready_in),
    .nr_reg_out     (bus.nr_reg_out),
    .nr_valid_out   (bus.nr_valid_out),
    .query_ps1      (bus.query_ps1),
    .query_ps2      (bus.query_ps2),
    .pr1_is_ready   (bus.pr1_is_ready),
    .pr2_is_ready   (bus.pr2_is_ready),
    .cdb_preg_in    (bus.cdb_preg_in),
    .cdb_valid_in   (bus.cdb_valid_in),
    .rob_we_out     (bus.rob_we_out),
    .rob_pd_new_out (bus.rob_pd_new_out),
    .rob_pd_old_out (bus.rob_pd_old_out),
    .rob_pc_out     (bus.rob_pc_out),
    .rob_tag_in     (bus.rob_tag_in),
    .rob_full_in    (bus.rob_full_in),
    .mispredict     (bus.mispredict),
    .err_out        (bus.err_out)
  );

  typedef struct packed {
    logic [NFU-1:0] sel;
    logic [PW-1:0]  prd;
    logic [PW-1:0]  ps1;
    logic           r1;
    logic           r2;
    logic [31:0]    pc;
    logic [PW-1:0]  pd_old;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic rename_data mk_pkt(input logic [PW-1:0] ps1, input logic [PW-1:0] ps2,
                                        input logic [PW-1:0] pd_new, input logic [PW-1:0] pd_old,
                                        input logic [31:0] pc);
    rename_data p;
    p.opcode = 7'h33;
    p.pc     = pc;
    p.func3  = 3'd1;
    p.func7  = 7'h20;
    p.imm    = pc ^ IMM_MASK;
    p.ps1    = ps1;
    p.ps2    = ps2;
    p.pd_new = pd_new;
    p.pd_old = pd_old;
    return p;
  endfunction

  function automatic exp_t mk_exp(input int ch, input rename_data p, input logic r1, input logic r2);
    exp_t e;
    e.sel    = NFU'(1 << ch);
    e.prd    = p.pd_new;
    e.ps1    = p.ps1;
    e.r1     = r1;
    e.r2     = r2;
    e.pc     = p.pc;
    e.pd_old = p.pd_old;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.valid_in  = 1'b0;
    bus.fu_sel_in = '0;
  endtask

  task automatic put(input int ch, input rename_data p);
    bus.valid_in  = 1'b1;
    bus.data_in   = p;
    bus.fu_sel_in = NFU'(1 << ch);
  endtask

  task automatic send(input int ch, input rename_data p);
    put(ch, p);
    @(negedge clk);
    check("ready_in_accept", 64'(bus.ready_in), 64'd1);
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Grant monitor: every strobe must match the next queued dispatch.
  always @(negedge clk) begin
    if (mon_en && bus.rs_valid_out != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 64'(bus.rs_valid_out), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("grant_sel",   64'(bus.rs_valid_out),          64'(e.sel));
        check("rs_prd",      64'(bus.rs_data_out.prd),       64'(e.prd));
        check("rs_pr1",      64'(bus.rs_data_out.pr1),       64'(e.ps1));
        check("rs_pr1_rdy",  64'(bus.rs_data_out.pr1_ready), 64'(e.r1));
        check("rs_pr2_rdy",  64'(bus.rs_data_out.pr2_ready), 64'(e.r2));
        check("rs_pc",       64'(bus.rs_data_out.pc),        64'(e.pc));
        check("rs_imm",      64'(bus.rs_data_out.imm),       64'(e.pc ^ IMM_MASK));
        check("rs_rob_idx",  64'(bus.rs_data_out.rob_index), 64'(ROB_TAG));
        check("nr_reg",      64'(bus.nr_reg_out),            64'(e.prd));
        check("rob_pd_new",  64'(bus.rob_pd_new_out),        64'(e.prd));
        check("rob_pd_old",  64'(bus.rob_pd_old_out),        64'(e.pd_old));
        check("rob_pc",      64'(bus.rob_pc_out),            64'(e.pc));
        check("strobes",     64'({bus.rob_we_out, bus.nr_valid_out}), 64'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rename_data p, pa, pb, pc, pd;
    bus.valid_in     = 1'b0;
    bus.data_in      = '0;
    bus.fu_sel_in    = '0;
    bus.rs_ready_in  = '0;
    bus.pr1_is_ready = 1'b0;
    bus.pr2_is_ready = 1'b0;
    bus.cdb_preg_in  = '0;
    bus.cdb_valid_in = '0;
    bus.rob_tag_in   = ROB_TAG;
    bus.rob_full_in  = 1'b0;
    bus.mispredict   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rs_valid", 64'(bus.rs_valid_out), 64'd0);
    check("rst_strobes",  64'({bus.rob_we_out, bus.nr_valid_out}), 64'd0);
    check("rst_payload",  64'(bus.rs_data_out == '0), 64'd1);
    check("rst_err",      64'(bus.err_out), 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Capture never dispatches in the same cycle; query ports follow data_in
    bus.rs_ready_in  = 3'b111;
    bus.pr1_is_ready = 1'b1;
    p = mk_pkt(7'd7, 7'd8, 7'd10, 7'd11, 32'h100);
    exp_q.push_back(mk_exp(0, p, 1'b1, 1'b0));
    put(0, p);
    @(negedge clk);
    check("latency_no_grant", 64'(bus.rs_valid_out), 64'd0);
    check("query_ps1", 64'(bus.query_ps1), 64'd7);
    check("query_ps2", 64'(bus.query_ps2), 64'd8);
    step();
    bus.pr1_is_ready = 1'b0;
    drain("drain_latency");

    // Held ALU packet woken by CDB two cycles after capture
    bus.rs_ready_in = 3'b110;
    p = mk_pkt(7'd5, 7'd0, 7'd9, 7'd4, 32'h200);
    exp_q.push_back(mk_exp(0, p, 1'b1, 1'b1));
    send(0, p);
    @(negedge clk);
    check("held_no_grant", 64'(bus.rs_valid_out), 64'd0);
    step();
    bus.cdb_valid_in = 3'b001;
    bus.cdb_preg_in  = {7'd0, 7'd0, 7'd5};
    @(negedge clk);
    check("held_no_grant2", 64'(bus.rs_valid_out), 64'd0);
    step();
    bus.cdb_valid_in = '0;
    bus.rs_ready_in  = 3'b111;
    drain("drain_cdb_wakeup");

    // Same-cycle CDB match at dispatch time, PRF ready at capture for ps2
    bus.rs_ready_in  = 3'b110;
    bus.pr2_is_ready = 1'b1;
    p = mk_pkt(7'd12, 7'd13, 7'd14, 7'd15, 32'h300);
    exp_q.push_back(mk_exp(0, p, 1'b1, 1'b1));
    send(0, p);
    bus.pr2_is_ready = 1'b0;
    bus.rs_ready_in  = 3'b111;
    bus.cdb_valid_in = 3'b100;
    bus.cdb_preg_in  = {7'd12, 7'd0, 7'd0};
    @(negedge clk);
    step();
    bus.cdb_valid_in = '0;
    drain("drain_same_cycle_cdb");

    // CDB match at capture on the branch channel
    bus.cdb_valid_in = 3'b010;
    bus.cdb_preg_in  = {7'd0, 7'd20, 7'd0};
    p = mk_pkt(7'd20, 7'd0, 7'd21, 7'd22, 32'h400);
    exp_q.push_back(mk_exp(1, p, 1'b1, 1'b1));
    send(1, p);
    bus.cdb_valid_in = '0;
    drain("drain_capture_cdb");

    // Round robin 0,1,2,0 from a fresh pointer, with slot 0 refilled while granted
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.rs_ready_in = 3'b000;
    pa = mk_pkt(7'd40, 7'd41, 7'd42, 7'd43, 32'h500);
    pb = mk_pkt(7'd44, 7'd45, 7'd46, 7'd47, 32'h504);
    pc = mk_pkt(7'd48, 7'd49, 7'd50, 7'd51, 32'h508);
    pd = mk_pkt(7'd52, 7'd53, 7'd54, 7'd55, 32'h50c);
    exp_q.push_back(mk_exp(0, pa, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1, pb, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(2, pc, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(0, pd, 1'b0, 1'b0));
    send(0, pa);
    send(1, pb);
    send(2, pc);
    bus.rs_ready_in = 3'b111;
    put(0, pd);
    @(negedge clk);
    check("recapture_ready", 64'(bus.ready_in), 64'd1);
    step();
    drain("drain_round_robin");

    // ROB full stalls grants only; branch still captured; pointer sits at 1
    bus.rob_full_in = 1'b1;
    pa = mk_pkt(7'd60, 7'd61, 7'd62, 7'd63, 32'h600);
    pb = mk_pkt(7'd64, 7'd65, 7'd66, 7'd67, 32'h604);
    exp_q.push_back(mk_exp(1, pb, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(0, pa, 1'b0, 1'b0));
    put(0, pa);
    @(negedge clk);
    check("robfull_no_we0", 64'(bus.rob_we_out), 64'd0);
    step();
    put(1, pb);
    @(negedge clk);
    check("robfull_br_ready", 64'(bus.ready_in), 64'd1);
    check("robfull_no_we1", 64'(bus.rob_we_out), 64'd0);
    step();
    @(negedge clk);
    check("robfull_no_we2", 64'(bus.rob_we_out), 64'd0);
    step();
    @(negedge clk);
    check("robfull_no_we3", 64'(bus.rob_we_out), 64'd0);
    step();
    bus.rob_full_in = 1'b0;
    @(negedge clk);
    check("robfull_resume", 64'(bus.rob_we_out), 64'd1);
    step();
    drain("drain_rob_full");

    // Mispredict with two held slots and an incoming packet
    bus.rs_ready_in = 3'b000;
    send(0, mk_pkt(7'd70, 7'd71, 7'd72, 7'd73, 32'h700));
    send(1, mk_pkt(7'd74, 7'd75, 7'd76, 7'd77, 32'h704));
    bus.rs_ready_in = 3'b111;
    bus.mispredict  = 1'b1;
    put(2, mk_pkt(7'd78, 7'd79, 7'd80, 7'd81, 32'h708));
    @(negedge clk);
    check("flush_ready_low", 64'(bus.ready_in), 64'd0);
    check("flush_no_grant", 64'(bus.rs_valid_out), 64'd0);
    check("flush_no_we", 64'(bus.rob_we_out), 64'd0);
    step();
    bus.mispredict = 1'b0;
    bus.fu_sel_in  = 3'b001;
    @(negedge clk);
    check("flush_slots_empty", 64'(bus.rs_valid_out), 64'd0);
    check("flush_slot0_free", 64'(bus.ready_in), 64'd1);
    step();

    // Bad channel selects are dropped and latch err_out
    put(0, mk_pkt(7'd82, 7'd83, 7'd84, 7'd85, 32'h800));
    bus.fu_sel_in = 3'b011;
    @(negedge clk);
    check("multihot_ready", 64'(bus.ready_in), 64'd0);
    check("err_before_edge", 64'(bus.err_out), 64'd0);
    @(posedge clk);
    #1;
    bus.fu_sel_in = 3'b000;
    @(negedge clk);
    check("zerosel_ready", 64'(bus.ready_in), 64'd0);
    check("err_set", 64'(bus.err_out), 64'd1);
    step();
    @(negedge clk);
    check("badsel_no_capture", 64'(bus.rs_valid_out), 64'd0);
    repeat (3) step();
    @(negedge clk);
    check("err_sticky", 64'(bus.err_out), 64'd1);
    step();

    // Reset with grants pending; pointer restarts at channel 0
    bus.rs_ready_in = 3'b000;
    send(1, mk_pkt(7'd90, 7'd91, 7'd92, 7'd93, 32'h900));
    send(2, mk_pkt(7'd94, 7'd95, 7'd96, 7'd97, 32'h904));
    bus.rs_ready_in = 3'b111;
    mon_en  = 1'b0;
    reset   = 1'b0;
    step();
    reset   = 1'b1;
    mon_en  = 1'b1;
    bus.data_in = '0;
    @(negedge clk);
    check("rst2_rs_valid", 64'(bus.rs_valid_out), 64'd0);
    check("rst2_strobes",  64'({bus.rob_we_out, bus.nr_valid_out}), 64'd0);
    check("rst2_payload",  64'(bus.rs_data_out == '0), 64'd1);
    check("rst2_rob_pl",   64'({bus.rob_pc_out, bus.rob_pd_new_out, bus.rob_pd_old_out, bus.nr_reg_out}), 64'd0);
    check("rst2_err",      64'(bus.err_out), 64'd0);
    step();
    bus.rs_ready_in = 3'b000;
    pa = mk_pkt(7'd100, 7'd101, 7'd102, 7'd103, 32'ha00);
    pb = mk_pkt(7'd104, 7'd105, 7'd106, 7'd107, 32'ha04);
    exp_q.push_back(mk_exp(0, pb, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(2, pa, 1'b0, 1'b0));
    send(2, pa);
    send(0, pb);
    bus.rs_ready_in = 3'b111;
    drain("drain_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_nch.md
DISPATCH_NCH -- requirements
Module: dispatch_nch

Interface
REQ-001 Parameter NUM_FU, default 3: number of FU channels (index 0 = ALU, 1 = branch, 2 = LSU).
REQ-002 Parameter NUM_CDB, default 3: number of CDB wakeup ports.
REQ-003 Parameter PREG_W, default 7: physical register tag width.
REQ-004 Parameter ROB_W, default 5: ROB tag width.
REQ-005 Ports, in order; the block SHALL provide exactly these:
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  rename packet valid.
- data_in  in  rename_data  rename packet.
- fu_sel_in  in  NUM_FU  one-hot target channel.
- ready_in  out  1  packet accepted this cycle.
- rs_valid_out  out  NUM_FU  per-RS write strobe.
- rs_data_out  out  dispatch_pipeline_data  payload shared by all RSs.
- rs_ready_in  in  NUM_FU  per-RS free space.
- nr_reg_out  out  PREG_W  pd_new to mark busy in the PRF.
- nr_valid_out  out  1  busy-mark strobe.
- query_ps1, query_ps2  out  PREG_W  PRF readiness query.
- pr1_is_ready, pr2_is_ready  in  1  PRF query result.
- cdb_preg_in  in  NUM_CDB*PREG_W  wakeup tags.
- cdb_valid_in  in  NUM_CDB  wakeup valids.
- rob_we_out  out  1  ROB allocate.
- rob_pd_new_out, rob_pd_old_out  out  PREG_W  ROB payload.
- rob_pc_out  out  32  ROB payload.
- rob_tag_in  in  ROB_W  next ROB tag.
- rob_full_in  in  1  ROB full.
- mispredict  in  1  flush.
- err_out  out  1  sticky bad-select flag.

Function
REQ-006 The block SHALL hold one entry per channel: valid bit, packet, r1 and r2 ready bits.
REQ-007 ready_in SHALL be high when mispredict is low, fu_sel_in is one-hot, and the selected slot is empty or is granted this cycle.
REQ-008 A capture (valid_in && ready_in) SHALL load the selected slot on the next edge; capture and grant on the same slot in one cycle is legal.
REQ-009 query_ps1/ps2 SHALL equal data_in.ps1/ps2 combinationally. At capture, rN = (psN==0) | prN_is_ready | any valid CDB tag == psN.
REQ-010 Each cycle, a held slot SHALL set rN when any valid CDB tag equals its psN; the bits never clear while held.
REQ-011 A slot c is eligible when it is valid, rs_ready_in[c] is high, rob_full_in is low and mispredict is low.
REQ-012 At most one grant SHALL occur per cycle, chosen round-robin starting from pointer rr_ptr; the pointer resets to 0 and becomes (winner+1) mod NUM_FU after each grant. It holds when there is no grant.
REQ-013 On a grant, the following SHALL be high for that cycle: rs_valid_out[winner] (one-hot), rob_we_out and nr_valid_out. The winner slot clears on the next edge unless it is recaptured.
REQ-014 rs_data_out fields:
- Opcode, pc, func3, func7 and imm[31:0] from the packet.
- prd = pd_new, pr1 = ps1, pr2 = ps2.
- rob_index = rob_tag_in.
- prN_ready = stored rN | same-cycle CDB match.
REQ-015 The ROB and PRF payloads (rob_pd_new_out, rob_pd_old_out, rob_pc_out, nr_reg_out) SHALL come from the winner packet; with no grant, all payload outputs are 0.
REQ-016 Latency: a packet captured in cycle T SHALL dispatch no earlier than T+1.
REQ-017 mispredict high SHALL clear every slot on the next edge. That cycle it also drops any incoming packet and suppresses grants; rr_ptr is unchanged.
REQ-018 valid_in high with fu_sel_in zero or multi-hot SHALL be discarded, with ready_in low and err_out set until reset.
REQ-019 A full ROB or full RS SHALL stall only grants; capture into empty slots continues.

Reset
REQ-020 When reset is low at an edge:
- all slots invalid, rr_ptr 0, err_out 0.
- all strobe and payload outputs 0 in the following cycle.
- reset overrides capture, grant and mispredict.

Structure
REQ-021 types_pkg SHALL own rename_data, dispatch_pipeline_data and the localparams FU_ALU=0, FU_BR=1, FU_MEM=2.
REQ-022 Sub-module dispatch_hold_slot SHALL implement one slot (REQ-006, REQ-009, REQ-010), instantiated NUM_FU times; arbitration and output muxing stay in dispatch_nch.

Verification
REQ-023 Packet (ps1=5, ps2=0, pd_new=9) to ALU; PRF not ready; CDB 5 arrives 2 cycles later -> dispatch with pr1_ready=1, pr2_ready=1, prd=9, nr_reg_out=9.
REQ-024 All three slots held and all RSs ready -> grants in order 0,1,2,0; rr_ptr wraps.
REQ-025 rob_full_in high for 4 cycles with the ALU slot held -> no rob_we_out; new branch packet captured; dispatch resumes the cycle after full drops.
REQ-026 mispredict with 2 slots held and valid_in high -> next cycle all slots empty, ready_in low in the flush cycle, no grant.
REQ-027 fu_sel_in=3'b011 with valid_in -> ready_in=0, no capture, err_out=1 until reset.
REQ-028 Reset low mid-stream with a grant pending -> next cycle all outputs 0; first post-reset grant goes to channel 0.
